// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage that feeds the IF/DE pipeline register. It owns
//   the PC and issues in-order word requests to instruction memory. Returned
//   words go into a small fetch buffer whose head drives the decode register.
//   A redirect from a later stage restarts fetch at a new PC, flushes the
//   buffer and drops responses to requests that are still in flight.
//
// Parameters
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  fetch-buffer entries (power of two, >=2); also the bound on
//               outstanding requests plus buffered words
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   imem_req/imem_addr       fetch request and its word address
//   imem_gnt                 memory accepts the request this cycle
//   imem_rvalid/imem_rdata   in-order response, latency >= 1
//   redirect_valid/_pc       change-of-flow pulse and target (bits [1:0] ignored)
//   de_ready                 decode register enable (0 = stall)
//   if_valid_out/inst/pc     head of the fetch buffer toward decode
//
// Configuration
//   IF_BUBBLE_NOP_EN  when defined, if_inst_out shows addi x0,x0,0 (32'h13)
//                     whenever if_valid_out=0; otherwise it shows zero.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        de_ready,
  output logic        if_valid_out,
  output logic [31:0] if_inst_out,
  output logic [31:0] if_pc_out
);

`ifdef IF_BUBBLE_NOP_EN
  localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [31:0]   pc_q, resp_pc, pc_hold;
  logic [CW-1:0] outstanding, discard_cnt, fifo_cnt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   mem_inst [FIFO_DEPTH];
  logic [31:0]   mem_pc   [FIFO_DEPTH];

  logic          hs, drop, push, pop;
  logic [CW:0]   inflight;
  logic [31:0]   redir_pc;
  logic [CW-1:0] redir_discard;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redir_pc = {redirect_pc[31:2], 2'b00};

  // Credits cover every in-flight request (including ones that will be
  // discarded) plus every buffered word, so a response always finds room.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_cnt};
  assign imem_req = (state_q != BOOT) && !redirect_valid &&
                    (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign hs = imem_req && imem_gnt;

  // A response arriving in the redirect cycle is stale and is never pushed.
  assign drop = imem_rvalid && (discard_cnt != '0);
  assign push = imem_rvalid && !drop && !redirect_valid;

  assign if_valid_out = (fifo_cnt != '0);
  assign pop = if_valid_out && de_ready && !redirect_valid;

  // After a redirect, everything still outstanding except a response landing
  // in the same cycle must be thrown away.
  assign redir_discard = outstanding - CW'(imem_rvalid);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (redir_discard != '0) ? DRAIN : RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        DRAIN:   if ((discard_cnt == '0) ||
                     (discard_cnt == CW'(1) && imem_rvalid)) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // PC, credit and discard bookkeeping, buffer pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      resp_pc     <= RESET_PC;
      pc_hold     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      fifo_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      // Remember what decode last saw so the PC output holds through bubbles.
      if (if_valid_out) pc_hold <= mem_pc[rd_ptr];

      if (redirect_valid) begin
        pc_q        <= redir_pc;
        resp_pc     <= redir_pc;
        outstanding <= redir_discard;
        discard_cnt <= redir_discard;
        fifo_cnt    <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (hs)   pc_q    <= pc_q + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        outstanding <= outstanding + CW'(hs) - CW'(imem_rvalid);
        if (drop) discard_cnt <= discard_cnt - CW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage carries no reset; only entries below fifo_cnt are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]   <= resp_pc;
    end
  end

  assign if_inst_out = if_valid_out ? mem_inst[rd_ptr] : BUBBLE;
  assign if_pc_out   = if_valid_out ? mem_pc[rd_ptr]   : pc_hold;

  // A push into a full buffer without a simultaneous pop means the memory
  // returned more words than were requested.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (fifo_cnt < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage. A queue-based instruction memory
//   returns addr ^ 32'hA5A5_0000 after a programmable latency. The reference
//   model is the architectural instruction stream: the next PC decode must
//   see, the next address fetch must request, and a redirect resets both.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0040;
  localparam logic [31:0] K   = 32'hA5A5_0000;
`ifdef IF_BUBBLE_NOP_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, de_ready;
  logic [31:0] redirect_pc;
  logic        if_valid_out;
  logic [31:0] if_inst_out, if_pc_out;

  if_fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .de_ready(de_ready),
    .if_valid_out(if_valid_out), .if_inst_out(if_inst_out), .if_pc_out(if_pc_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  int errors = 0, checks = 0;
  int cyc = 0, lat = 1, delivered = 0;
  logic [31:0] exp_pc, exp_req;
  logic        s_req, s_hs, s_valid, s_rv;
  logic [31:0] s_addr, s_pc, s_inst;

  // One clock cycle: present the memory response, sample outputs away from
  // the edge, then advance the memory model across the rising edge.
  task automatic step();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr ^ K;
    end
    #1;
    s_req = imem_req; s_hs = imem_req & imem_gnt; s_addr = imem_addr;
    s_valid = if_valid_out; s_pc = if_pc_out; s_inst = if_inst_out;
    s_rv = imem_rvalid;
    @(posedge clk);
    if (s_rv) void'(mq.pop_front());
    if (s_hs) mq.push_back('{s_addr, cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (imem_req !== 1'b0 || if_valid_out !== 1'b0 || imem_addr !== RPC ||
        if_pc_out !== RPC || if_inst_out !== BUB) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h pc=%h inst=%h required 0 0 %h %h %h",
               imem_req, if_valid_out, imem_addr, if_pc_out, if_inst_out, RPC, RPC, BUB);
    end
    rst = 1'b0;
    exp_pc = RPC; exp_req = RPC;
    step();
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL boot_no_req: req=%b required 0", s_req);
    end
  endtask

  // Free-running fetch with redirect low; checks every sampled cycle.
  task automatic test_stream(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (s_valid) begin
        if (s_pc !== exp_pc || s_inst !== (exp_pc ^ K)) begin
          errors++;
          $display("FAIL stream_data: pc=%h inst=%h required pc=%h inst=%h",
                   s_pc, s_inst, exp_pc, exp_pc ^ K);
        end
        if (de_ready) begin exp_pc += 32'd4; delivered++; end
      end else if (s_inst !== BUB) begin
        errors++; $display("FAIL stream_bubble: inst=%h required %h", s_inst, BUB);
      end
      if (s_hs) begin
        checks++;
        if (s_addr !== exp_req) begin
          errors++; $display("FAIL stream_addr: addr=%h required %h", s_addr, exp_req);
        end
        exp_req += 32'd4;
      end
    end
  endtask

  task automatic test_throughput();
    int d0;
    imem_gnt = 1'b1; de_ready = 1'b1; lat = 1;
    d0 = delivered;
    test_stream(30);
    checks++;
    if (delivered - d0 < 15) begin
      errors++; $display("FAIL stream_progress: delivered=%0d required >=15", delivered - d0);
    end
  endtask

  task automatic test_stall();
    int hs_cnt = 0;
    logic [31:0] held;
    test_stream(5);
    de_ready = 1'b0;
    held = exp_pc;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== held || s_inst !== (held ^ K)) begin
        errors++;
        $display("FAIL stall_hold: valid=%b pc=%h inst=%h required 1 %h %h",
                 s_valid, s_pc, s_inst, held, held ^ K);
      end
      if (s_hs) begin
        hs_cnt++;
        checks++;
        if (s_addr !== exp_req) begin
          errors++; $display("FAIL stall_addr: addr=%h required %h", s_addr, exp_req);
        end
        exp_req += 32'd4;
      end
    end
    checks++;
    if (hs_cnt > 2 || s_req !== 1'b0) begin
      errors++; $display("FAIL stall_credits: requests=%0d req=%b required <=2 and 0", hs_cnt, s_req);
    end
    de_ready = 1'b1;
    test_stream(20);
  endtask

  task automatic test_redirect();
    int guard = 0, d0;
    lat = 3;
    while (mq.size() != 2 && guard < 30) begin test_stream(1); guard++; end
    checks++;
    if (mq.size() != 2) begin
      errors++; $display("FAIL redirect_setup: outstanding=%0d required 2", mq.size());
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL redirect_req: req=%b required 0", s_req);
    end
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_0100; exp_req = 32'h0000_0100;
    step();
    checks++;
    if (s_valid !== 1'b0 || s_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL redirect_next: valid=%b addr=%h required 0 00000100", s_valid, s_addr);
    end
    if (s_hs) exp_req += 32'd4;
    d0 = delivered;
    test_stream(30);
    checks++;
    if (delivered == d0) begin
      errors++; $display("FAIL redirect_progress: delivered=0 required >0");
    end
    lat = 1;
  endtask

  task automatic test_redirect_same_cycle();
    int guard = 0, n_out;
    logic [31:0] tgt;
    lat = 1;
    while (!(if_valid_out && mq.size() > 0 && mq[0].due <= cyc) && guard < 30) begin
      test_stream(1); guard++;
    end
    n_out = mq.size();
    checks++;
    if (!(if_valid_out && n_out > 0)) begin
      errors++; $display("FAIL same_setup: valid=%b outstanding=%0d required 1 and >0", if_valid_out, n_out);
    end
    tgt = $urandom;
    redirect_valid = 1'b1; redirect_pc = tgt; de_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    exp_pc = {tgt[31:2], 2'b00}; exp_req = exp_pc;
    checks++;
    if (if_valid_out !== 1'b0 || int'(dut.discard_cnt) != n_out - 1) begin
      errors++;
      $display("FAIL same_cycle: valid=%b discard=%0d required 0 %0d",
               if_valid_out, dut.discard_cnt, n_out - 1);
    end
    test_stream(15);
  endtask

  task automatic test_reset_mid();
    test_stream(7);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || if_valid_out !== 1'b0 || imem_addr !== RPC ||
        if_pc_out !== RPC || if_inst_out !== BUB) begin
      errors++;
      $display("FAIL reset_mid: req=%b valid=%b addr=%h pc=%h inst=%h required 0 0 %h %h %h",
               imem_req, if_valid_out, imem_addr, if_pc_out, if_inst_out, RPC, RPC, BUB);
    end
    mq.delete();
    imem_rvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_pc = RPC; exp_req = RPC;
    step();
    checks++;
    if (s_req !== 1'b0) begin
      errors++; $display("FAIL reset_boot: req=%b required 0", s_req);
    end
    step();
    checks++;
    if (s_req !== 1'b1 || s_addr !== RPC) begin
      errors++; $display("FAIL reset_first_req: req=%b addr=%h required 1 %h", s_req, s_addr, RPC);
    end
    if (s_hs) exp_req += 32'd4;
    test_stream(15);
  endtask

  task automatic test_random();
    logic prev_redir = 1'b0, redir;
    logic [31:0] tgt;
    int d0 = delivered;
    for (int i = 0; i < 400; i++) begin
      imem_gnt = ($urandom_range(3) != 0);
      de_ready = ($urandom_range(2) != 0);
      redir    = ($urandom_range(24) == 0);
      tgt      = $urandom;
      lat      = $urandom_range(3, 1);
      redirect_valid = redir; redirect_pc = tgt;
      step();
      checks++;
      if (prev_redir && s_valid) begin
        errors++; $display("FAIL rand_after_redirect: valid=1 required 0");
      end
      if (s_valid) begin
        if (s_pc !== exp_pc || s_inst !== (exp_pc ^ K)) begin
          errors++;
          $display("FAIL rand_data: pc=%h inst=%h required pc=%h inst=%h",
                   s_pc, s_inst, exp_pc, exp_pc ^ K);
        end
        if (de_ready && !redir) begin exp_pc += 32'd4; delivered++; end
      end else if (s_inst !== BUB) begin
        errors++; $display("FAIL rand_bubble: inst=%h required %h", s_inst, BUB);
      end
      if (redir && s_req) begin
        checks++; errors++; $display("FAIL rand_redirect_req: req=1 required 0");
      end
      if (s_hs) begin
        checks++;
        if (s_addr !== exp_req) begin
          errors++; $display("FAIL rand_addr: addr=%h required %h", s_addr, exp_req);
        end
        exp_req += 32'd4;
      end
      if (redir) begin exp_pc = {tgt[31:2], 2'b00}; exp_req = exp_pc; end
      prev_redir = redir;
    end
    redirect_valid = 1'b0; imem_gnt = 1'b1; de_ready = 1'b1; lat = 1;
    checks++;
    if (delivered - d0 < 20) begin
      errors++; $display("FAIL rand_progress: delivered=%0d required >=20", delivered - d0);
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; de_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_throughput();
    test_stall();
    test_redirect();
    test_redirect_same_cycle();
    test_reset_mid();
    test_random();
    test_stream(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
